// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer: Moore FSM with memory wait-state timeout and trap.
// Optional addi support is built when MCFSM_ADDI_EN is defined.
module multicycle_ctrl_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       trap,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
`ifdef MCFSM_ADDI_EN
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
`endif
    TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef MCFSM_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  // pc_write/branch/fetch/memwr are qualifiers later combined with zero or mem_ready
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       fetch;
    logic       memwr;
    logic       done;
    logic       trap;
  } dec_t;

  function automatic dec_t decode(input state_t s);
    dec_t d;
    d = '0;
    case (s)
      FETCH:  begin d.mem_read = 1'b1; d.alu_src_b = 2'b01; d.fetch = 1'b1; end
      DECODE: begin d.alu_src_b = 2'b11; end
      MEMADR: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      MEMRD:  begin d.mem_read = 1'b1; d.iord = 1'b1; end
      MEMWB:  begin d.mem_to_reg = 1'b1; d.reg_write = 1'b1; d.done = 1'b1; end
      MEMWR:  begin d.mem_write = 1'b1; d.iord = 1'b1; d.memwr = 1'b1; end
      EXEC:   begin d.alu_src_a = 1'b1; d.alu_op = 2'b10; end
      ALUWB:  begin d.reg_dst = 1'b1; d.reg_write = 1'b1; d.done = 1'b1; end
      BRANCH: begin
        d.alu_src_a = 1'b1; d.alu_op = 2'b01; d.pc_src = 2'b01;
        d.branch = 1'b1; d.done = 1'b1;
      end
      JUMP:   begin d.pc_src = 2'b10; d.pc_write = 1'b1; d.done = 1'b1; end
`ifdef MCFSM_ADDI_EN
      ADDIEX: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      ADDIWB: begin d.reg_write = 1'b1; d.done = 1'b1; end
`endif
      TRAP:   begin d.trap = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic rdy, input logic tmo);
    state_t n;
    n = TRAP;
    case (s)
      FETCH:  n = rdy ? DECODE : (tmo ? TRAP : FETCH);
      DECODE: begin
        case (op)
          OP_R:          n = EXEC;
          OP_LW, OP_SW:  n = MEMADR;
          OP_BEQ:        n = BRANCH;
          OP_J:          n = JUMP;
`ifdef MCFSM_ADDI_EN
          OP_ADDI:       n = ADDIEX;
`endif
          default:       n = TRAP;
        endcase
      end
      MEMADR: n = (op == OP_LW) ? MEMRD : ((op == OP_SW) ? MEMWR : TRAP);
      MEMRD:  n = rdy ? MEMWB : (tmo ? TRAP : MEMRD);
      MEMWR:  n = rdy ? FETCH : (tmo ? TRAP : MEMWR);
      EXEC:   n = ALUWB;
`ifdef MCFSM_ADDI_EN
      ADDIEX: n = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: n = FETCH;
`else
      MEMWB, ALUWB, BRANCH, JUMP: n = FETCH;
`endif
      TRAP:   n = TRAP;
      default: n = TRAP;
    endcase
    return n;
  endfunction

  state_t           st_r;
  dec_t             dec_r;
  logic [CNT_W-1:0] cnt_r;
  logic             bus_err_r;
  logic             is_mem_s;
  logic             timeout_s;
  state_t           nxt_s;

  assign is_mem_s  = (st_r == FETCH) || (st_r == MEMRD) || (st_r == MEMWR);
  assign timeout_s = is_mem_s && !mem_ready && (cnt_r == CNT_W'(WAIT_LIMIT));
  assign nxt_s     = next_state(st_r, opcode, mem_ready, timeout_s);

  // State, registered output decode of the next state, wait counter and sticky bus error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_r      <= FETCH;
      dec_r     <= decode(FETCH);
      cnt_r     <= '0;
      bus_err_r <= 1'b0;
    end else begin
      st_r  <= nxt_s;
      dec_r <= decode(nxt_s);
      if (nxt_s != st_r) begin
        cnt_r <= '0;
      end else if (is_mem_s && !mem_ready) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (timeout_s) begin
        bus_err_r <= 1'b1;
      end else begin
        bus_err_r <= bus_err_r;
      end
    end
  end

  assign iord       = dec_r.iord;
  assign mem_read   = dec_r.mem_read;
  assign mem_write  = dec_r.mem_write;
  assign reg_dst    = dec_r.reg_dst;
  assign mem_to_reg = dec_r.mem_to_reg;
  assign reg_write  = dec_r.reg_write;
  assign alu_src_a  = dec_r.alu_src_a;
  assign alu_src_b  = dec_r.alu_src_b;
  assign alu_op     = dec_r.alu_op;
  assign pc_src     = dec_r.pc_src;
  assign trap       = dec_r.trap;
  assign bus_err    = bus_err_r;
  assign state      = st_r;
  // Only the memory handshake and the branch condition bypass the registered decode
  assign ir_write   = dec_r.fetch & mem_ready;
  assign pc_en      = (dec_r.fetch & mem_ready) | dec_r.pc_write | (dec_r.branch & zero);
  assign instr_done = dec_r.done | (dec_r.memwr & mem_ready);

endmodule
